// File: rtl/stepper_bank.sv
// rtl/stepper_bank.sv - six-axis step/direction pulse generator
//
// Each axis compares its signed 32-bit target with its live position while
// idle. If they differ (and motion is enabled) it runs one step:
//   IDLE -> SETUP (DIR_SETUP) -> HIGH (PULSE_HIGH) -> LOW (PULSE_LOW) -> IDLE
// The position moves by one on the clock edge where the pulse rises.
//
// Optional build macro: STEPPER_SOFT_LIMIT_EN clamps every target to
// [-POS_LIMIT, +POS_LIMIT] before the idle comparison.
//
// Ports:
//   CLK                 system clock
//   RST_n               synchronous active-low reset
//   stepCnt             six signed 32-bit targets, axis i at [32i+31:32i]
//   currentLoopPowerOn  driver power request, registered onto powerEN
//   currentLoopEnable   motion enable, checked only when an axis is idle
//   stepperPosition     six signed 32-bit positions, same packing as stepCnt
//   powerEN             per-axis driver enable
//   thrusterPluse       per-axis step pulse
//   thrusterDirect      per-axis direction, 1 = increasing position
module stepper_bank #(
  parameter int DIR_SETUP  = 2,
  parameter int PULSE_HIGH = 4,
  parameter int PULSE_LOW  = 4,
  parameter int POS_LIMIT  = 100000
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic [191:0] stepCnt,
  input  logic         currentLoopPowerOn,
  input  logic         currentLoopEnable,
  output logic [191:0] stepperPosition,
  output logic [5:0]   powerEN,
  output logic [5:0]   thrusterPluse,
  output logic [5:0]   thrusterDirect
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  // Phase counters count 0 .. length-1 inside each timed phase.
  localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
  localparam logic [15:0] HIGH_LAST  = 16'(PULSE_HIGH - 1);
  localparam logic [15:0] LOW_LAST   = 16'(PULSE_LOW - 1);

  state_t             state_q [6];
  state_t             state_d [6];
  logic [15:0]        cnt_q   [6];
  logic [15:0]        cnt_d   [6];
  logic signed [31:0] pos_q   [6];
  logic signed [31:0] pos_d   [6];
  logic signed [31:0] tgt     [6];
  logic [5:0]         dir_q, dir_d;
  logic [5:0]         pulse_q, pulse_d;
  logic [5:0]         power_q;

`ifdef STEPPER_SOFT_LIMIT_EN
  localparam logic signed [31:0] LIM_HI = 32'(POS_LIMIT);
  localparam logic signed [31:0] LIM_LO = -32'(POS_LIMIT);

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      tgt[i] = $signed(stepCnt[32*i +: 32]);
      if (tgt[i] > LIM_HI) begin
        tgt[i] = LIM_HI;
      end else if (tgt[i] < LIM_LO) begin
        tgt[i] = LIM_LO;
      end
    end
  end
`else
  // The limit only matters when the clamp is compiled in.
  logic unused_pos_limit;
  assign unused_pos_limit = ^POS_LIMIT;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      tgt[i] = $signed(stepCnt[32*i +: 32]);
    end
  end
`endif

  always_comb begin
    dir_d   = dir_q;
    pulse_d = 6'b0;
    for (int i = 0; i < 6; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pos_d[i]   = pos_q[i];
      case (state_q[i])
        S_IDLE: begin
          // Direction and the decision to step are only taken here, so a
          // step already under way always completes unchanged.
          if (currentLoopEnable && (tgt[i] != pos_q[i])) begin
            dir_d[i]   = (tgt[i] > pos_q[i]);
            state_d[i] = S_SETUP;
            cnt_d[i]   = 16'd0;
          end
        end
        S_SETUP: begin
          if (cnt_q[i] == SETUP_LAST) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = 16'd0;
            pulse_d[i] = 1'b1;
            pos_d[i]   = dir_q[i] ? pos_q[i] + 32'sd1 : pos_q[i] - 32'sd1;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        S_HIGH: begin
          if (cnt_q[i] == HIGH_LAST) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = 16'd0;
          end else begin
            pulse_d[i] = 1'b1;
            cnt_d[i]   = cnt_q[i] + 16'd1;
          end
        end
        default: begin
          if (cnt_q[i] == LOW_LAST) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = 16'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < 6; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 16'd0;
        pos_q[i]   <= 32'sd0;
      end
      dir_q   <= 6'b0;
      pulse_q <= 6'b0;
      power_q <= 6'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pos_q[i]   <= pos_d[i];
      end
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      power_q <= {6{currentLoopPowerOn}};
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_pos
    assign stepperPosition[32*g +: 32] = pos_q[g];
  end

  assign powerEN        = power_q;
  assign thrusterPluse  = pulse_q;
  assign thrusterDirect = dir_q;

endmodule

// File: tb/tb_stepper_bank.sv
// tb/tb_stepper_bank.sv - self-checking bench for stepper_bank
module tb_stepper_bank;
  localparam int DS  = 2;
  localparam int PH  = 4;
  localparam int PL  = 4;
  localparam int LIM = 3;
  localparam int BUSY = DS + PH + PL;

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic [191:0] stepCnt = '0;
  logic         currentLoopPowerOn = 1'b0;
  logic         currentLoopEnable = 1'b0;
  logic [191:0] stepperPosition;
  logic [5:0]   powerEN;
  logic [5:0]   thrusterPluse;
  logic [5:0]   thrusterDirect;

  int checks = 0;
  int errors = 0;

  stepper_bank #(
    .DIR_SETUP (DS),
    .PULSE_HIGH(PH),
    .PULSE_LOW (PL),
    .POS_LIMIT (LIM)
  ) dut (
    .CLK               (CLK),
    .RST_n             (RST_n),
    .stepCnt           (stepCnt),
    .currentLoopPowerOn(currentLoopPowerOn),
    .currentLoopEnable (currentLoopEnable),
    .stepperPosition   (stepperPosition),
    .powerEN           (powerEN),
    .thrusterPluse     (thrusterPluse),
    .thrusterDirect    (thrusterDirect)
  );

  always #5 CLK = ~CLK;

  // Reference model: each axis is "idle" (age 0) or counts the cycles since
  // it committed to a step. The pulse is high for ages DS+1..DS+PH and the
  // position moves as age reaches DS+1.
  int                 m_age [6];
  logic signed [31:0] m_pos [6];
  logic [5:0]         m_dir = '0, m_pulse = '0, m_pwr = '0;
  logic [191:0]       m_posv = '0;
  logic signed [31:0] m_t;

  initial begin
    for (int i = 0; i < 6; i++) begin
      m_age[i] = 0;
      m_pos[i] = 0;
    end
  end

  always @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < 6; i++) begin
        m_age[i] = 0;
        m_pos[i] = 0;
      end
      m_dir = '0;
      m_pulse = '0;
      m_pwr = '0;
    end else begin
      m_pwr = {6{currentLoopPowerOn}};
      for (int i = 0; i < 6; i++) begin
        m_t = $signed(stepCnt[32*i +: 32]);
`ifdef STEPPER_SOFT_LIMIT_EN
        if (m_t > LIM) m_t = LIM;
        if (m_t < -LIM) m_t = -LIM;
`endif
        if (m_age[i] == 0) begin
          if (currentLoopEnable && m_t != m_pos[i]) begin
            m_dir[i] = (m_t > m_pos[i]);
            m_age[i] = 1;
          end
        end else begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] > BUSY) m_age[i] = 0;
          else if (m_age[i] == DS + 1) m_pos[i] = m_dir[i] ? m_pos[i] + 1 : m_pos[i] - 1;
        end
        m_pulse[i] = (m_age[i] >= DS + 1) && (m_age[i] <= DS + PH);
      end
    end
    for (int i = 0; i < 6; i++) m_posv[32*i +: 32] = m_pos[i];
  end

  task automatic set_tgt(input int axis, input int val);
    stepCnt[32*axis +: 32] = 32'(val);
  endtask

  task automatic pulse_reset();
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    stepCnt = '0;
    currentLoopEnable = 1'b0;
    currentLoopPowerOn = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== 210'd0) begin
        errors++;
        $display("FAIL reset_state: got %h required 0", {stepperPosition, powerEN, thrusterPluse, thrusterDirect});
      end
    end
    RST_n = 1'b1;
  endtask

  task automatic test_single_axis();
    int rises = 0, hl = 0, cyc = 0, last_rise = -1;
    logic prev = 1'b0;
    currentLoopEnable = 1'b1;
    set_tgt(0, 5);
    repeat (5 * 11 + 12) begin
      @(negedge CLK);
      cyc++;
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_single: got %h required %h", {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
      if (thrusterPluse[0] && !prev) begin
        rises++;
        checks++;
        if (thrusterDirect[0] !== 1'b1) begin
          errors++;
          $display("FAIL single_dir: got %b required 1", thrusterDirect[0]);
        end
        if (last_rise >= 0) begin
          checks++;
          if (cyc - last_rise != 11) begin
            errors++;
            $display("FAIL single_spacing: got %0d required 11", cyc - last_rise);
          end
        end
        last_rise = cyc;
      end
      if (thrusterPluse[0]) hl++;
      if (!thrusterPluse[0] && prev) begin
        checks++;
        if (hl != PH) begin
          errors++;
          $display("FAIL single_width: got %0d required %0d", hl, PH);
        end
        hl = 0;
      end
      prev = thrusterPluse[0];
    end
    checks++;
    if (rises != 5) begin
      errors++;
      $display("FAIL single_count: got %0d required 5", rises);
    end
    checks++;
    if (stepperPosition !== 192'd5) begin
      errors++;
      $display("FAIL single_pos: got %h required 5 on axis0 only", stepperPosition);
    end
  endtask

  task automatic test_reverse();
    int rises = 0, dl = 0;
    logic prev = 1'b0;
    set_tgt(0, -3);
    repeat (8 * 11 + 12) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_reverse: got %h required %h", {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
      dl = thrusterDirect[0] ? 0 : dl + 1;
      if (thrusterPluse[0] && !prev) begin
        rises++;
        checks++;
        if (dl < DS + 1) begin
          errors++;
          $display("FAIL reverse_setup: dir low %0d cycles at rise, required >= %0d", dl, DS + 1);
        end
      end
      prev = thrusterPluse[0];
    end
    checks++;
    if (rises != 8) begin
      errors++;
      $display("FAIL reverse_count: got %0d required 8", rises);
    end
    checks++;
    if (stepperPosition[31:0] !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL reverse_pos: got %h required fffffffd", stepperPosition[31:0]);
    end
  endtask

  task automatic test_enable_gate();
    int rises = 0;
    bit seen = 0;
    logic prev = 1'b0;
    currentLoopEnable = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++) set_tgt(i, 10);
    repeat (30) begin
      @(negedge CLK);
      checks++;
      if (thrusterPluse !== 6'b0) begin
        errors++;
        $display("FAIL gate_idle: got pulses %b required 000000", thrusterPluse);
      end
    end
    currentLoopEnable = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_gate: got %h required %h", {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
      if (thrusterPluse[0] && !prev) rises++;
      prev = thrusterPluse[0];
      if (rises == 3) begin
        seen = 1;
        currentLoopEnable = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL gate_third_pulse: got %0d rises required 3 within budget", rises);
    end
    repeat (40) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (stepperPosition[32*i +: 32] !== 32'd3) begin
        errors++;
        $display("FAIL gate_stop_axis%0d: got %0d required 3", i, stepperPosition[32*i +: 32]);
      end
    end
  endtask

  task automatic test_retarget();
    int rises = 0, maxp = 0;
    bit seen = 0;
    logic prev = 1'b0;
    stepCnt = '0;
    pulse_reset();
    currentLoopEnable = 1'b1;
    set_tgt(0, 7);
    for (int c = 0; c < 5 * 11 + 40; c++) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_retarget: got %h required %h", {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
      if ($signed(stepperPosition[31:0]) > maxp) maxp = $signed(stepperPosition[31:0]);
      if (thrusterPluse[0] && !prev) rises++;
      prev = thrusterPluse[0];
      if (rises == 2 && !seen) begin
        seen = 1;
        set_tgt(0, 0);
      end
    end
    checks++;
    if (maxp != 2) begin
      errors++;
      $display("FAIL retarget_peak: got %0d required 2", maxp);
    end
    checks++;
    if (stepperPosition[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL retarget_final: got %0d required 0", stepperPosition[31:0]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int rises = 0;
    bit seen = 0;
    logic prev = 1'b0;
    currentLoopPowerOn = 1'b1;
    set_tgt(0, 10);
    for (int c = 0; c < 70 && !seen; c++) begin
      @(negedge CLK);
      if (thrusterPluse[0] && !prev) rises++;
      prev = thrusterPluse[0];
      if (rises == 4) seen = 1;
    end
    checks++;
    if (!seen || stepperPosition[31:0] !== 32'd4) begin
      errors++;
      $display("FAIL midreset_reach: got pos %0d seen %0d required pos 4", stepperPosition[31:0], seen);
    end
    RST_n = 1'b0;
    @(negedge CLK);
    checks++;
    if ({thrusterPluse[0], stepperPosition[31:0], powerEN} !== 39'd0) begin
      errors++;
      $display("FAIL midreset_clear: got pulse %b pos %0d pwr %b required 0", thrusterPluse[0], stepperPosition[31:0], powerEN);
    end
    RST_n = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_midreset: got %h required %h", {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
    end
    checks++;
    if ($signed(stepperPosition[31:0]) < 1) begin
      errors++;
      $display("FAIL midreset_restart: got %0d required > 0", stepperPosition[31:0]);
    end
  endtask

  task automatic test_power();
    currentLoopPowerOn = 1'b0;
    @(negedge CLK);
    currentLoopPowerOn = 1'b1;
    @(negedge CLK);
    checks++;
    if (powerEN !== 6'b111111) begin
      errors++;
      $display("FAIL power_on: got %b required 111111", powerEN);
    end
    currentLoopPowerOn = 1'b0;
    @(negedge CLK);
    checks++;
    if (powerEN !== 6'b000000) begin
      errors++;
      $display("FAIL power_off: got %b required 000000", powerEN);
    end
  endtask

  task automatic test_soft_limit();
    int req;
`ifdef STEPPER_SOFT_LIMIT_EN
    req = LIM;
`else
    req = 8;
`endif
    stepCnt = '0;
    pulse_reset();
    currentLoopEnable = 1'b1;
    set_tgt(0, 8);
    repeat (9 * 11 + 10) @(negedge CLK);
    checks++;
    if ($signed(stepperPosition[31:0]) != req) begin
      errors++;
      $display("FAIL soft_limit: got %0d required %0d", $signed(stepperPosition[31:0]), req);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      checks++;
      if ({stepperPosition, powerEN, thrusterPluse, thrusterDirect} !== {m_posv, m_pwr, m_pulse, m_dir}) begin
        errors++;
        $display("FAIL model_random cycle %0d: got %h required %h", c, {stepperPosition, powerEN, thrusterPluse, thrusterDirect}, {m_posv, m_pwr, m_pulse, m_dir});
      end
      if ($urandom_range(0, 29) == 0) set_tgt($urandom_range(0, 5), $urandom_range(0, 12) - 6);
      if ($urandom_range(0, 39) == 0) currentLoopEnable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) currentLoopPowerOn = $urandom_range(0, 1);
      RST_n = ($urandom_range(0, 299) != 0);
    end
    RST_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_axis();
    test_reverse();
    test_enable_gate();
    test_retarget();
    test_reset_mid_pulse();
    test_power();
    test_soft_limit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
